demosaic_param: RTL and testbench
=================================

Name: demosaic_param

Overview:
- Parametrised bilinear Bayer demosaic engine.
- Streams one raw frame in raster order into three per-channel pixel memories (R, G, B). It then interpolates the two missing channels at every pixel, border pixels included, and writes them back.
- Generalises the fixed 128x128 / 8-bit / GRBG-only engine:
  - configurable frame size and pixel width;
  - runtime Bayer pattern select;
  - mirrored border interpolation;
  - load stall;
  - frame restart after done.

Parameters:
- COL_BITS, 7, log2 of frame width W (W = 2^COL_BITS, at least 2).
- ROW_BITS, 7, log2 of frame height H (H = 2^ROW_BITS, at least 2).
- DW, 8, pixel/sample width in bits.
- Derived localparam AW = ROW_BITS+COL_BITS, the address width. Address = {row, col}.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- in_en  input  1  raw pixel valid. data_in is sampled on each clk edge where in_en=1 (IDLE/LOAD/DONE).
- data_in  input  DW  raw Bayer sample.
- cfg_pattern  input  2  Bayer pattern: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR. Latched on frame start.
- wr_r / wr_g / wr_b  output  1 each  write strobe per channel memory.
- addr_r / addr_g / addr_b  output  AW each  memory address.
- wdata_r / wdata_g / wdata_b  output  DW each  write data.
- rdata_r / rdata_g / rdata_b  input  DW each  read data. Asynchronous-read memory: valid in the same cycle addr_x is driven; the engine samples it at the next edge.
- busy  output  1  high in LOAD, FETCH, WRITE.
- done  output  1  frame complete; held until next frame start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE;
  - all wr_x=0, addr_x=0, wdata_x=0, busy=0, done=0;
  - counters and accumulators 0;
  - memory contents untouched.
  - Reset mid-frame aborts the frame; the next in_en starts a new frame.
- Site colour of pixel (r,c): index (r[0]^p[1], c[0]^p[0]) into the RGGB map (00=R, 01=G, 10=G, 11=B), where p is the latched pattern.
  - "G in R-row" means the G site whose row contains R sites.
- States: IDLE, LOAD, FETCH, WRITE, DONE.
- IDLE/DONE with in_en=1:
  - latch cfg_pattern;
  - capture pixel 0;
  - clear done;
  - go to LOAD.
- LOAD: each in_en=1 edge captures pixel k (k = 0..W*H-1).
  - Next cycle: wr of the site channel only =1, addr=k, wdata=data_in. Other channels have wr=0, addr=0.
  - in_en=0 stalls: no write that cycle, k holds.
  - After pixel W*H-1 is captured, go to FETCH with centre=0.
- Neighbour coordinates use mirroring, which preserves Bayer parity: index -1 maps to 1, index W (or H) maps to W-2 (or H-2).
- Interpolation per site; both missing channels are read in parallel on their own buses:
  - R site: G = mean of N, S, W, E. B = mean of NW, NE, SW, SE. 4 fetch cycles.
  - B site: symmetric. R = diagonals, G = orthogonals. 4 fetch cycles.
  - G in R-row: R = mean of W, E; B = mean of N, S. 2 fetch cycles.
  - G in B-row: R = mean of N, S; B = mean of W, E. 2 fetch cycles.
- FETCH:
  - Cycle i drives neighbour address i; the sample is accumulated at the following edge.
  - Accumulators are DW+2 bits, with no overflow.
  - Idle channel bus: wr=0, addr=0.
- WRITE: one cycle.
  - Both missing channels: wr=1, addr=centre, wdata = sum>>2 (4-tap) or sum>>1 (2-tap). Truncating.
  - The site channel is not written.
  - Then centre+1 and back to FETCH. After centre W*H-1, go to DONE.
- Per-pixel cost: R/B sites 5 cycles, G sites 3 cycles. No dead cycles between pixels.
- DONE: done=1, busy=0, all wr=0. Holds until in_en=1, which restarts per IDLE.
- in_en is ignored in FETCH/WRITE.

Test Plan:
- COL_BITS=ROW_BITS=2, pattern 0, all 16 samples = 100 -> every R, G, B location = 100. done rises after 16 load writes plus 64 interpolation cycles.
- COL_BITS=ROW_BITS=3, pattern 0, sample = raster index -> R at (1,1) = (0+2+16+18)>>2 = 9. G at (1,1) = (1+8+10+17)>>2 = 9.
- Same frame, corner (0,0) R site, mirrored -> G = (1+8+1+8)>>2 = 4, B = 9. Corner (7,7) B site -> R = (54+54+54+54)>>2 = 54.
- Same frame with pattern 3 (BGGR) -> (0,0) treated as B: wr_b=1 at addr 0 during load; after interpolation R(0,0) = 9, G(0,0) = 4.
- All samples 255 (DW=8) -> outputs 255 (sum 1020 with no overflow). in_en low for 3 cycles mid-load -> no writes during the gap, addresses contiguous.
- reset=0 during FETCH -> outputs 0 immediately, done=0. A new in_en frame completes correctly. A second frame started from DONE clears done on its first in_en cycle.

Source files
------------

// File: rtl/demosaic_param.sv
// Parametrised bilinear Bayer demosaic: streams a raw frame into external R/G/B memories,
// then fills in the two missing channels at every pixel using mirrored neighbours.
module demosaic_param #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 7,
  parameter int DW       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_en,
  input  logic [DW-1:0]                data_in,
  input  logic [1:0]                   cfg_pattern,
  output logic                         wr_r,
  output logic                         wr_g,
  output logic                         wr_b,
  output logic [ROW_BITS+COL_BITS-1:0] addr_r,
  output logic [ROW_BITS+COL_BITS-1:0] addr_g,
  output logic [ROW_BITS+COL_BITS-1:0] addr_b,
  output logic [DW-1:0]                wdata_r,
  output logic [DW-1:0]                wdata_g,
  output logic [DW-1:0]                wdata_b,
  input  logic [DW-1:0]                rdata_r,
  input  logic [DW-1:0]                rdata_g,
  input  logic [DW-1:0]                rdata_b,
  output logic                         busy,
  output logic                         done
);
  localparam int AW = ROW_BITS + COL_BITS;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_WRITE, S_DONE} state_t;
  // Index into the RGGB quad: SITE_GR is the G that shares its row with R sites.
  typedef enum logic [1:0] {SITE_R = 2'b00, SITE_GR = 2'b01, SITE_GB = 2'b10, SITE_B = 2'b11} site_t;
  typedef struct packed { logic [AW-1:0] a_r; logic [AW-1:0] a_g; logic [AW-1:0] a_b; } addr3_t;
  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } bus_t;

  function automatic site_t site_of(input logic [AW-1:0] a, input logic [1:0] pat);
    return site_t'({a[COL_BITS] ^ pat[1], a[0] ^ pat[0]});
  endfunction

  function automatic logic [DW-1:0] mean(input logic [DW+1:0] s, input logic four);
    return DW'(four ? (s >> 2) : (s >> 1));
  endfunction

  // Neighbour addresses read on each channel bus at a given fetch step; unused buses stay 0.
  function automatic addr3_t fetch_addrs(input logic [AW-1:0] ctr, input logic [1:0] pat,
                                         input logic [1:0] step);
    logic [ROW_BITS-1:0] r, rn, rs;
    logic [COL_BITS-1:0] c, cw, ce;
    logic [AW-1:0]       orth, diag, horiz, vert;
    addr3_t              a;
    r  = ctr[AW-1:COL_BITS];
    c  = ctr[COL_BITS-1:0];
    // Mirroring keeps Bayer parity: -1 maps to 1 and the far edge+1 maps to edge-1.
    rn = (r == '0) ? ROW_BITS'(1) : r - ROW_BITS'(1);
    rs = (r == '1) ? r - ROW_BITS'(1) : r + ROW_BITS'(1);
    cw = (c == '0) ? COL_BITS'(1) : c - COL_BITS'(1);
    ce = (c == '1) ? c - COL_BITS'(1) : c + COL_BITS'(1);
    case (step)
      2'd0:    begin orth = {rn, c}; diag = {rn, cw}; end
      2'd1:    begin orth = {rs, c}; diag = {rn, ce}; end
      2'd2:    begin orth = {r, cw}; diag = {rs, cw}; end
      default: begin orth = {r, ce}; diag = {rs, ce}; end
    endcase
    horiz = step[0] ? {r, ce} : {r, cw};
    vert  = step[0] ? {rs, c} : {rn, c};
    a = '0;
    case (site_of(ctr, pat))
      SITE_R:  begin a.a_g = orth;  a.a_b = diag;  end
      SITE_B:  begin a.a_r = diag;  a.a_g = orth;  end
      SITE_GR: begin a.a_r = horiz; a.a_b = vert;  end
      default: begin a.a_r = vert;  a.a_b = horiz; end
    endcase
    return a;
  endfunction

  state_t          state;
  logic [1:0]      pattern;
  logic [AW-1:0]   k, centre;
  logic [1:0]      step;
  logic            load_last;
  logic [DW+1:0]   acc_r, acc_g, acc_b;

  site_t           cur_site, cap_site;
  logic            capture, use_r, use_g, use_b, last_step;
  logic [AW-1:0]   cap_addr, nxt_ctr;
  logic [1:0]      nxt_step;
  logic [DW+1:0]   sum_r, sum_g, sum_b;
  addr3_t          nxt_addr;
  bus_t            bus_r, bus_g, bus_b;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bus_r = '0;
    bus_g = '0;
    bus_b = '0;
    capture   = in_en && (state == S_IDLE || state == S_DONE || (state == S_LOAD && !load_last));
    cap_addr  = (state == S_LOAD) ? k : '0;
    cap_site  = site_of(cap_addr, (state == S_LOAD) ? pattern : cfg_pattern);
    cur_site  = site_of(centre, pattern);
    use_r     = cur_site != SITE_R;
    use_b     = cur_site != SITE_B;
    use_g     = cur_site == SITE_R || cur_site == SITE_B;
    last_step = use_g ? (step == 2'd3) : (step == 2'd1);
    sum_r     = use_r ? acc_r + (DW+2)'(rdata_r) : acc_r;
    sum_g     = use_g ? acc_g + (DW+2)'(rdata_g) : acc_g;
    sum_b     = use_b ? acc_b + (DW+2)'(rdata_b) : acc_b;
    nxt_ctr   = (state == S_WRITE) ? centre + AW'(1) : centre;
    nxt_step  = (state == S_FETCH) ? step + 2'd1 : 2'd0;
    nxt_addr  = fetch_addrs(nxt_ctr, pattern, nxt_step);

    if (capture) begin
      case (cap_site)
        SITE_R:  begin bus_r.wr = 1'b1; bus_r.addr = cap_addr; bus_r.wdata = data_in; end
        SITE_B:  begin bus_b.wr = 1'b1; bus_b.addr = cap_addr; bus_b.wdata = data_in; end
        default: begin bus_g.wr = 1'b1; bus_g.addr = cap_addr; bus_g.wdata = data_in; end
      endcase
    end else if ((state == S_LOAD && load_last) || (state == S_FETCH && !last_step) ||
                 (state == S_WRITE && centre != '1)) begin
      bus_r.addr = nxt_addr.a_r;
      bus_g.addr = nxt_addr.a_g;
      bus_b.addr = nxt_addr.a_b;
    end else if (state == S_FETCH) begin
      // Final fetch edge: registers the write-back of both missing channels.
      bus_r.wr    = use_r;
      bus_r.addr  = use_r ? centre : '0;
      bus_r.wdata = use_r ? mean(sum_r, use_g) : '0;
      bus_g.wr    = use_g;
      bus_g.addr  = use_g ? centre : '0;
      bus_g.wdata = use_g ? mean(sum_g, 1'b1) : '0;
      bus_b.wr    = use_b;
      bus_b.addr  = use_b ? centre : '0;
      bus_b.wdata = use_b ? mean(sum_b, use_g) : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pattern   <= '0;
      k         <= '0;
      centre    <= '0;
      step      <= '0;
      load_last <= 1'b0;
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
      {wr_r, addr_r, wdata_r} <= '0;
      {wr_g, addr_g, wdata_g} <= '0;
      {wr_b, addr_b, wdata_b} <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      {wr_r, addr_r, wdata_r} <= bus_r;
      {wr_g, addr_g, wdata_g} <= bus_g;
      {wr_b, addr_b, wdata_b} <= bus_b;
      case (state)
        S_IDLE, S_DONE: if (in_en) begin
          pattern   <= cfg_pattern;
          k         <= AW'(1);
          centre    <= '0;
          step      <= '0;
          load_last <= 1'b0;
          busy      <= 1'b1;
          done      <= 1'b0;
          state     <= S_LOAD;
        end
        S_LOAD: if (load_last) begin
          load_last <= 1'b0;
          step      <= '0;
          state     <= S_FETCH;
        end else if (in_en) begin
          k         <= k + AW'(1);
          load_last <= (k == '1);
        end
        S_FETCH: if (last_step) begin
          acc_r <= '0;
          acc_g <= '0;
          acc_b <= '0;
          step  <= '0;
          state <= S_WRITE;
        end else begin
          acc_r <= sum_r;
          acc_g <= sum_g;
          acc_b <= sum_b;
          step  <= step + 2'd1;
        end
        S_WRITE: if (centre == '1) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          centre <= centre + AW'(1);
          state  <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demosaic_param.sv
// Directed bench for demosaic_param on an 8x8 frame: load writes, interpolated values against a
// bilinear reference, done latency, stall, restart from DONE and reset during interpolation.
module tb_demosaic_param;
  localparam int CB = 3;
  localparam int RB = 3;
  localparam int DW = 8;
  localparam int W = 1 << CB;
  localparam int H = 1 << RB;
  localparam int NPIX = W * H;
  localparam int AW = CB + RB;
  // Half the sites are R/B (5 cycles), half are G (3 cycles), plus the final load write.
  localparam int DONE_LAT = 1 + (NPIX / 2) * 5 + (NPIX / 2) * 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_en;
  logic [DW-1:0] data_in;
  logic [1:0]    cfg_pattern;
  logic          wr_r, wr_g, wr_b;
  logic [AW-1:0] addr_r, addr_g, addr_b;
  logic [DW-1:0] wdata_r, wdata_g, wdata_b;
  logic [DW-1:0] rdata_r, rdata_g, rdata_b;
  logic          busy, done;

  logic [DW-1:0] mem_r [NPIX];
  logic [DW-1:0] mem_g [NPIX];
  logic [DW-1:0] mem_b [NPIX];

  int checks = 0;
  int errors = 0;
  int frame_id = 0;

  demosaic_param #(.COL_BITS(CB), .ROW_BITS(RB), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .data_in(data_in), .cfg_pattern(cfg_pattern),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
    .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
    .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_r) mem_r[addr_r] <= wdata_r;
    if (wr_g) mem_g[addr_g] <= wdata_g;
    if (wr_b) mem_b[addr_b] <= wdata_b;
  end
  assign rdata_r = mem_r[addr_r];
  assign rdata_g = mem_g[addr_g];
  assign rdata_b = mem_b[addr_b];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pix(input int img, input int idx);
    case (img)
      0:       return 100;
      1:       return idx;
      2:       return 255;
      default: return (idx * 7 + 3) & 255;
    endcase
  endfunction

  function automatic int mir(input int i, input int n);
    if (i < 0) return 1;
    if (i >= n) return n - 2;
    return i;
  endfunction

  // 0 R, 1 G in R-row, 2 G in B-row, 3 B
  function automatic int site(input int r, input int c, input int pat);
    return ((((r & 1) ^ ((pat >> 1) & 1))) << 1) | ((c & 1) ^ (pat & 1));
  endfunction

  function automatic int px(input int img, input int r, input int c);
    return pix(img, mir(r, H) * W + mir(c, W));
  endfunction

  function automatic int expect_ch(input int img, input int pat, input int r, input int c,
                                   input int ch);
    int s, own, orth, diag, hz, vt;
    s    = site(r, c, pat);
    own  = px(img, r, c);
    hz   = px(img, r, c - 1) + px(img, r, c + 1);
    vt   = px(img, r - 1, c) + px(img, r + 1, c);
    orth = hz + vt;
    diag = px(img, r - 1, c - 1) + px(img, r - 1, c + 1) + px(img, r + 1, c - 1) + px(img, r + 1, c + 1);
    case (s)
      0:       return (ch == 0) ? own : (ch == 1) ? (orth >> 2) : (diag >> 2);
      3:       return (ch == 0) ? (diag >> 2) : (ch == 1) ? (orth >> 2) : own;
      1:       return (ch == 0) ? (hz >> 1) : (ch == 1) ? own : (vt >> 1);
      default: return (ch == 0) ? (vt >> 1) : (ch == 1) ? own : (hz >> 1);
    endcase
  endfunction

  task automatic check_write(input int k, input int s, input int val);
    int exp_wr, got_a, got_d;
    exp_wr = (s == 0) ? 4 : (s == 3) ? 1 : 2;
    case (s)
      0:       begin got_a = int'(addr_r); got_d = int'(wdata_r); end
      3:       begin got_a = int'(addr_b); got_d = int'(wdata_b); end
      default: begin got_a = int'(addr_g); got_d = int'(wdata_g); end
    endcase
    check($sformatf("f%0d_ld%0d_wr", frame_id, k), int'({wr_r, wr_g, wr_b}), exp_wr);
    check($sformatf("f%0d_ld%0d_addr", frame_id, k), got_a, k);
    check($sformatf("f%0d_ld%0d_data", frame_id, k), got_d, val);
  endtask

  // Pattern is only presented on the first pixel, so a latch failure shows up as wrong sites.
  task automatic run_load(input int img, input int pat, input int stall_at);
    for (int k = 0; k < NPIX; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          in_en = 1'b0;
          @(posedge clk);
          #1;
          check($sformatf("f%0d_stall%0d_wr", frame_id, s), int'({wr_r, wr_g, wr_b}), 0);
        end
      end
      @(negedge clk);
      in_en       = 1'b1;
      data_in     = DW'(pix(img, k));
      cfg_pattern = (k == 0) ? 2'(pat) : 2'(pat ^ 3);
      @(posedge clk);
      #1;
      if (k == 0) begin
        check($sformatf("f%0d_start_done", frame_id), int'(done), 0);
        check($sformatf("f%0d_start_busy", frame_id), int'(busy), 1);
      end
      check_write(k, site(k / W, k % W, pat), pix(img, k));
    end
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic wait_done(input int junk);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2 * DONE_LAT) begin
      in_en   = (n < junk);
      data_in = 8'hAA;
      @(posedge clk);
      #1;
      n++;
    end
    in_en = 1'b0;
    check($sformatf("f%0d_done_lat", frame_id), n, DONE_LAT);
    check($sformatf("f%0d_done_busy", frame_id), int'(busy), 0);
    check($sformatf("f%0d_done_wr", frame_id), int'({wr_r, wr_g, wr_b}), 0);
  endtask

  task automatic check_frame(input int img, input int pat);
    int got;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int ch = 0; ch < 3; ch++) begin
          got = (ch == 0) ? int'(mem_r[r * W + c]) : (ch == 1) ? int'(mem_g[r * W + c]) : int'(mem_b[r * W + c]);
          check($sformatf("f%0d_px%0d_%0d_ch%0d", frame_id, r, c, ch), got, expect_ch(img, pat, r, c, ch));
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    in_en       = 1'b0;
    data_in     = '0;
    cfg_pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", int'({wr_r, wr_g, wr_b}), 0);
    check("rst_addr", int'(addr_r) + int'(addr_g) + int'(addr_b), 0);
    check("rst_wdata", int'(wdata_r) + int'(wdata_g) + int'(wdata_b), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);

    // Flat frame: every channel reconstructs to the flat value.
    frame_id = 1;
    run_load(0, 0, -1);
    wait_done(0);
    check_frame(0, 0);

    // Ramp, RGGB, with in_en toggled during interpolation.
    frame_id = 2;
    run_load(1, 0, -1);
    wait_done(20);
    check_frame(1, 0);
    check("ramp_r11", int'(mem_r[9]), 9);
    check("ramp_g11", int'(mem_g[9]), 9);
    check("ramp_g00", int'(mem_g[0]), 4);
    check("ramp_b00", int'(mem_b[0]), 9);
    check("ramp_r77", int'(mem_r[63]), 54);

    // Same ramp, BGGR, restarted from DONE.
    frame_id = 3;
    run_load(1, 3, -1);
    wait_done(0);
    check_frame(1, 3);
    check("bggr_r00", int'(mem_r[0]), 9);
    check("bggr_g00", int'(mem_g[0]), 4);

    // Saturated frame, GRBG, with a 3-cycle stall mid-load.
    frame_id = 4;
    run_load(2, 1, 20);
    wait_done(0);
    check_frame(2, 1);

    // Reset while interpolating.
    frame_id = 5;
    run_load(1, 0, -1);
    repeat (30) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_wr", int'({wr_r, wr_g, wr_b}), 0);
    check("mid_rst_addr", int'(addr_r) + int'(addr_g) + int'(addr_b), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;

    // Fresh frame after the abort, GBRG.
    frame_id = 6;
    run_load(3, 2, -1);
    wait_done(0);
    check_frame(3, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
